// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous imem request, 2-entry prefetch queue
// and the {PC, instruction} IF_ID register consumed by decode.
module fetch_unit #(
  parameter int                 DATA_W    = 32,
  parameter logic [31:0]        RESET_PC  = 32'h0,
  parameter int                 IMEM_AW   = 8,
  parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h3800_0000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic [31+DATA_W:0]  IF_ID,
  output logic                if_valid,
  output logic                halted
);

  localparam int         ENT_W  = 32 + DATA_W;
  localparam logic [5:0] OP_HLT = 6'b001101;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  function automatic logic is_hlt(input logic [5:0] opcode);
    return opcode == OP_HLT;
  endfunction

  state_t             state;
  logic [31:0]        pc_p0;
  logic [31:0]        req_pc_p1;
  logic               vld_p1;
  logic [ENT_W-1:0]   q_data [2];
  logic [1:0]         q_cnt;
  logic [ENT_W-1:0]   if_id_p2;
  logic               vld_p2;
  logic               halted_p2;

  logic               pop;
  logic               push;
  logic               hlt_pop;
  logic               flush;
  logic               issue;
  logic [2:0]         occ;
  logic [ENT_W-1:0]   rsp_ent;

  // Occupancy counts the word already in flight so the queue can never overflow.
  always_comb begin
    pop     = (q_cnt != 2'd0) && !stall;
    hlt_pop = pop && (state == ST_RUN) && is_hlt(q_data[0][DATA_W-1 -: 6]);
    flush   = branch_taken || hlt_pop;
    push    = vld_p1 && !flush;
    occ     = {1'b0, q_cnt} + {2'b00, vld_p1} - {2'b00, pop};
    issue   = (state == ST_RUN) && !flush && (occ < 3'd2);
    rsp_ent = {req_pc_p1, imem_rdata};
  end

  assign imem_en   = issue;
  assign imem_addr = pc_p0[IMEM_AW-1:0];
  assign IF_ID     = if_id_p2;
  assign if_valid  = vld_p2;
  assign halted    = halted_p2;

  // p0 -> p1: request PC follows the read into the memory.
  always_ff @(posedge clock) begin
    if (issue) begin
      req_pc_p1 <= pc_p0;
    end
  end

  // p1 -> queue: returned word joins the FIFO; head always sits in slot 0.
  always_ff @(posedge clock) begin
    if (pop) begin
      q_data[0] <= (q_cnt == 2'd2) ? q_data[1] : rsp_ent;
      if (push) begin
        q_data[1] <= rsp_ent;
      end
    end else if (push) begin
      if (q_cnt == 2'd0) begin
        q_data[0] <= rsp_ent;
      end else begin
        q_data[1] <= rsp_ent;
      end
    end
  end

  // queue -> p2: redirect beats stall, pop and HLT detection on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      pc_p0     <= RESET_PC;
      vld_p1    <= 1'b0;
      q_cnt     <= 2'd0;
      if_id_p2  <= {32'h0, NOP_INSTR};
      vld_p2    <= 1'b0;
      halted_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (flush) begin
        q_cnt <= 2'd0;
      end else begin
        q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
      end

      if (branch_taken) begin
        state     <= ST_RUN;
        halted_p2 <= 1'b0;
        pc_p0     <= branch_target;
        if_id_p2  <= {branch_target, NOP_INSTR};
        vld_p2    <= 1'b0;
      end else begin
        if (issue) begin
          pc_p0 <= pc_p0 + 32'd1;
        end
        if (!stall) begin
          if (q_cnt != 2'd0) begin
            if_id_p2 <= q_data[0];
            vld_p2   <= 1'b1;
          end else begin
            if_id_p2 <= {pc_p0, NOP_INSTR};
            vld_p2   <= 1'b0;
          end
        end
        if (hlt_pop) begin
          state     <= ST_HALT;
          halted_p2 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect traffic,
// all compared against a queue-based model of the fetch behaviour.
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h3800_0000;
  localparam logic [31:0] HLT    = 32'h3400_0000;
  localparam logic [5:0]  OP_HLT = 6'b001101;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] IF_ID;
  logic        if_valid;
  logic        halted;

  fetch_unit #(
    .DATA_W(32), .RESET_PC(32'h0), .IMEM_AW(8), .NOP_INSTR(32'h3800_0000)
  ) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .IF_ID(IF_ID), .if_valid(if_valid), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [256];
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a fetch queue of {pc, instr} entries plus one outstanding read.
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_infl_pc;
  bit          m_infl, m_halt, m_vld;
  logic [63:0] m_ifid;

  task automatic m_reset();
    m_q.delete();
    m_pc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0;
    m_halt = 1'b0; m_vld = 1'b0; m_ifid = {32'h0, NOP};
  endtask

  function automatic bit m_pop();
    return (m_q.size() != 0) && !stall;
  endfunction

  function automatic bit m_hlt_pop();
    if (m_q.size() == 0 || stall || m_halt) return 1'b0;
    return m_q[0][31:26] == OP_HLT;
  endfunction

  function automatic bit m_en();
    int n;
    n = m_q.size() + (m_infl ? 1 : 0) - (m_pop() ? 1 : 0);
    return !m_halt && !branch_taken && !m_hlt_pop() && (n < 2);
  endfunction

  task automatic m_step();
    bit          en, resp_ok;
    logic [63:0] resp, head;
    en = m_en();
    if (branch_taken) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = branch_target;
      m_ifid = {branch_target, NOP};
      m_vld  = 1'b0;
      m_halt = 1'b0;
    end else begin
      resp_ok = m_infl;
      resp    = {m_infl_pc, mem[m_infl_pc[7:0]]};
      if (!stall) begin
        if (m_q.size() != 0) begin
          head   = m_q.pop_front();
          m_ifid = head;
          m_vld  = 1'b1;
          if (!m_halt && head[31:26] == OP_HLT) begin
            m_halt = 1'b1;
            m_q.delete();
            resp_ok = 1'b0;
          end
        end else begin
          m_ifid = {m_pc, NOP};
          m_vld  = 1'b0;
        end
      end
      if (resp_ok) m_q.push_back(resp);
      if (en) begin
        m_infl = 1'b1; m_infl_pc = m_pc; m_pc = m_pc + 32'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit st, input bit br, input logic [31:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    #1;
    check("imem_en", 64'(imem_en), 64'(m_en()));
    check("imem_addr", 64'(imem_addr), 64'(m_pc[7:0]));
    @(posedge clock);
    m_step();
    @(negedge clock);
    check("if_id", IF_ID, m_ifid);
    check("if_valid", 64'(if_valid), 64'(m_vld));
    check("halted", 64'(halted), 64'(m_halt));
  endtask

  bit          st, br;
  logic [31:0] tgt, w;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    for (int i = 160; i < 256; i++) begin
      w = $urandom;
      if (w[31:26] == OP_HLT) w[31:26] = 6'b0;
      if ($urandom_range(0, 15) == 0) w[31:26] = OP_HLT;
      mem[i] = w;
    end
    mem[8'h53] = HLT;
    mem[8'h73] = HLT;

    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    m_reset();
    @(negedge clock);
    check("rst_ifid", IF_ID, {32'h0, NOP});
    check("rst_valid", 64'(if_valid), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Start-up latency and streaming
    repeat (3) cycle(0, 0, 0);
    check("first_instr", IF_ID, {32'h0, 32'h0});
    check("first_valid", 64'(if_valid), 64'h1);
    repeat (4) cycle(0, 0, 0);
    check("pc4", IF_ID, {32'h4, 32'h4});

    // Stall holds IF_ID while the queue fills
    repeat (5) cycle(1, 0, 0);
    check("stall_hold", IF_ID, {32'h4, 32'h4});
    check("stall_no_fetch", 64'(imem_en), 64'h0);
    for (int k = 5; k <= 7; k++) begin
      cycle(0, 0, 0);
      check("stall_release", IF_ID, {32'(k), 32'(k)});
    end

    // Redirect while queue holds 8, 9
    cycle(1, 0, 0);
    cycle(1, 1, 32'h40);
    check("br_bubble", IF_ID, {32'h40, NOP});
    check("br_valid", 64'(if_valid), 64'h0);
    repeat (3) cycle(0, 0, 0);
    check("br_target", IF_ID, {32'h40, 32'h40});

    // HLT at 0x53
    cycle(0, 1, 32'h50);
    for (int i = 0; i < 12 && !halted; i++) cycle(0, 0, 0);
    check("hlt_halted", 64'(halted), 64'h1);
    check("hlt_ifid", IF_ID, {32'h53, HLT});
    repeat (4) cycle(0, 0, 0);
    check("hlt_bubble", 64'(IF_ID[31:0]), 64'(NOP));
    check("hlt_valid", 64'(if_valid), 64'h0);
    check("hlt_no_fetch", 64'(imem_en), 64'h0);

    // Redirect out of HALT
    cycle(0, 1, 32'h60);
    check("unhalt", 64'(halted), 64'h0);
    repeat (3) cycle(0, 0, 0);
    check("unhalt_fetch", IF_ID, {32'h60, 32'h60});

    // Redirect on the edge the HLT at 0x73 would pop
    cycle(0, 1, 32'h70);
    for (int i = 0; i < 12 && IF_ID[63:32] != 32'h72; i++) cycle(0, 0, 0);
    check("at_72", 64'(IF_ID[63:32]), 64'h72);
    cycle(0, 1, 32'h80);
    check("br_hlt_halted", 64'(halted), 64'h0);
    check("br_hlt_ifid", IF_ID, {32'h80, NOP});
    repeat (3) cycle(0, 0, 0);
    check("br_hlt_resume", IF_ID, {32'h80, 32'h80});

    // PC wrap
    cycle(0, 1, 32'hFFFF_FFFE);
    repeat (6) cycle(0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else tgt = 32'($urandom_range(0, 255));
      cycle(st, br, tgt);
    end

    // Asynchronous reset mid-stream with stall held
    cycle(0, 1, 32'h10);
    repeat (5) cycle(0, 0, 0);
    repeat (2) cycle(1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check("arst_ifid", IF_ID, {32'h0, NOP});
    check("arst_valid", 64'(if_valid), 64'h0);
    check("arst_halted", 64'(halted), 64'h0);
    check("arst_addr", 64'(imem_addr), 64'h0);
    check("arst_en", 64'(imem_en), 64'(m_en()));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) cycle(0, 0, 0);
    check("restart", IF_ID, {32'h0, 32'h0});
    repeat (3) cycle(0, 0, 0);
    check("restart_seq", IF_ID, {32'h3, 32'h3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
